// File: rtl/bootrom_responder_if.sv
// Boot ROM responder bus: loader-side byte read handshake plus backing word port.
// The responder attaches through the slave modport; the loader/backing side uses master.
interface bootrom_responder_if #(
   parameter int unsigned BACK_AW = 10
) ();
   logic [31:0]        rom_addr;
   logic               rom_read_en;
   logic [7:0]         rom_data_out;
   logic               rom_ready;
   logic [BACK_AW-1:0] back_addr;
   logic               back_rd;
   logic [31:0]        back_data;
   logic               back_valid;
   logic               inval;
   logic               range_err;

   modport slave (
      input  rom_addr, rom_read_en, back_data, back_valid, inval,
      output rom_data_out, rom_ready, back_addr, back_rd, range_err
   );

   modport master (
      output rom_addr, rom_read_en, back_data, back_valid, inval,
      input  rom_data_out, rom_ready, back_addr, back_rd, range_err
   );
endinterface

// File: rtl/bootrom_responder.sv
// Byte-wide boot ROM read responder with a one-word buffer in front of a
// variable-latency 32-bit backing ROM; flags reads beyond ROM_BYTES.
module bootrom_responder #(
   parameter int unsigned ROM_BYTES = 4096,
   parameter int unsigned BACK_AW   = 10
) (
   input  logic              clk,
   input  logic              rst,
   bootrom_responder_if.slave bus
);
   localparam int unsigned TAG_W     = 30;
   localparam logic [31:0] ROM_LIMIT = 32'(ROM_BYTES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOOKUP,
      S_FETCH,
      S_WAIT,
      S_RESPOND,
      S_GAP
   } state_t;

   state_t             state_q,     state_d;
   logic [31:0]        req_addr_q,  req_addr_d;
   logic               buf_valid_q, buf_valid_d;
   logic [TAG_W-1:0]   buf_tag_q,   buf_tag_d;
   logic [31:0]        buf_data_q,  buf_data_d;
   logic [7:0]         data_q,      data_d;
   logic               ready_q,     ready_d;
   logic               back_rd_q,   back_rd_d;
   logic [BACK_AW-1:0] back_addr_q, back_addr_d;
   logic               range_err_q, range_err_d;

   logic               out_of_range_c;
   logic               buf_hit_c;

   // Little-endian byte lane pick from a 32-bit word.
   function automatic logic [7:0] lane_sel(input logic [31:0] word, input logic [1:0] lane);
      logic [7:0] b;
      case (lane)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      return b;
   endfunction

   // Full 32-bit compare: addresses never wrap into the ROM window.
   assign out_of_range_c = (req_addr_q >= ROM_LIMIT);
   assign buf_hit_c      = buf_valid_q && (buf_tag_q == req_addr_q[31:2]);

   always_comb begin
      state_d     = state_q;
      req_addr_d  = req_addr_q;
      buf_valid_d = buf_valid_q;
      buf_tag_d   = buf_tag_q;
      buf_data_d  = buf_data_q;
      data_d      = data_q;
      ready_d     = 1'b0;
      back_rd_d   = 1'b0;
      back_addr_d = back_addr_q;
      range_err_d = range_err_q;

      case (state_q)
         S_IDLE: begin
            if (bus.rom_read_en) begin
               req_addr_d = bus.rom_addr;
               state_d    = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            if (out_of_range_c) begin
               data_d      = 8'h00;
               range_err_d = 1'b1;
               ready_d     = 1'b1;
               state_d     = S_RESPOND;
            end else if (buf_hit_c) begin
               data_d  = lane_sel(buf_data_q, req_addr_q[1:0]);
               ready_d = 1'b1;
               state_d = S_RESPOND;
            end else begin
               back_rd_d   = 1'b1;
               back_addr_d = req_addr_q[BACK_AW+1:2];
               state_d     = S_FETCH;
            end
         end
         S_FETCH: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (bus.back_valid) begin
               buf_valid_d = 1'b1;
               buf_tag_d   = req_addr_q[31:2];
               buf_data_d  = bus.back_data;
               data_d      = lane_sel(bus.back_data, req_addr_q[1:0]);
               ready_d     = 1'b1;
               state_d     = S_RESPOND;
            end
         end
         S_RESPOND: begin
            state_d = S_GAP;
         end
         S_GAP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Invalidate wins over a same-cycle fill; the in-flight byte is still returned.
      if (bus.inval) begin
         buf_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         req_addr_q  <= 32'h0;
         buf_valid_q <= 1'b0;
         buf_tag_q   <= '0;
         buf_data_q  <= 32'h0;
         data_q      <= 8'h00;
         ready_q     <= 1'b0;
         back_rd_q   <= 1'b0;
         back_addr_q <= '0;
         range_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         req_addr_q  <= req_addr_d;
         buf_valid_q <= buf_valid_d;
         buf_tag_q   <= buf_tag_d;
         buf_data_q  <= buf_data_d;
         data_q      <= data_d;
         ready_q     <= ready_d;
         back_rd_q   <= back_rd_d;
         back_addr_q <= back_addr_d;
         range_err_q <= range_err_d;
      end
   end

   assign bus.rom_data_out = data_q;
   assign bus.rom_ready    = ready_q;
   assign bus.back_rd      = back_rd_q;
   assign bus.back_addr    = back_addr_q;
   assign bus.range_err    = range_err_q;

endmodule

// File: tb/tb_bootrom_responder.sv
// Scoreboard bench for bootrom_responder: a backing ROM model with programmable
// latency answers fetches; expected bytes and latencies are queued per request.
module tb_bootrom_responder;
   localparam int unsigned ROM_BYTES  = 4096;
   localparam int unsigned BACK_AW    = 10;
   localparam int          KIND_HIT   = 0;
   localparam int          KIND_MISS  = 1;
   localparam int          KIND_RANGE = 2;

   typedef struct {
      logic [7:0] data;
      int         kind;
      int         cap_cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bootrom_responder_if #(.BACK_AW(BACK_AW)) bus ();

   logic inval_drv;
   logic inval_fill;
   assign bus.inval = inval_drv | inval_fill;

   bootrom_responder #(
      .ROM_BYTES (ROM_BYTES),
      .BACK_AW   (BACK_AW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t exp_q[$];

   int                 back_lat    = 3;
   bit                 fill_inval  = 1'b0;
   bit                 stray_req   = 1'b0;
   int                 valid_cyc   = -1;
   int                 back_rd_cnt = 0;
   logic [BACK_AW-1:0] exp_back_addr = '0;
   bit                 mdl_valid   = 1'b0;
   logic [29:0]        mdl_tag     = '0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] rom_word(input logic [BACK_AW-1:0] widx);
      if (widx == BACK_AW'(12)) return 32'h44332211;
      if (widx == BACK_AW'(16)) return 32'hDDCCBBAA;
      return {8'h5A ^ 8'(widx), 8'(widx), 8'hC3, ~8'(widx)};
   endfunction

   function automatic logic [7:0] rom_byte(input logic [31:0] a);
      logic [31:0] w;
      w = rom_word(a[BACK_AW+1:2]);
      w = w >> {a[1:0], 3'b000};
      return w[7:0];
   endfunction

   // Backing ROM model: answers each back_rd after back_lat cycles (withheld if <= 0).
   initial begin
      logic [BACK_AW-1:0] widx;
      bus.back_valid = 1'b0;
      bus.back_data  = 32'h0;
      inval_fill     = 1'b0;
      forever begin
         @(negedge clk);
         if (stray_req) begin
            stray_req      = 1'b0;
            bus.back_data  = 32'hDEADBEEF;
            bus.back_valid = 1'b1;
            @(negedge clk);
            bus.back_valid = 1'b0;
         end else if (bus.back_rd === 1'b1) begin
            back_rd_cnt++;
            widx = bus.back_addr;
            check_eq("back_addr", 32'(bus.back_addr), 32'(exp_back_addr));
            if (back_lat > 0) begin
               repeat (back_lat) @(negedge clk);
               check_eq("back_addr_hold", 32'(bus.back_addr), 32'(widx));
               bus.back_data  = rom_word(widx);
               bus.back_valid = 1'b1;
               inval_fill     = fill_inval;
               valid_cyc      = cyc;
               @(negedge clk);
               bus.back_valid = 1'b0;
               inval_fill     = 1'b0;
            end
         end
      end
   end

   // Response monitor: every ready pulse pops one expectation.
   always @(negedge clk) begin
      exp_t m;
      if (bus.rom_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            check_eq("spurious_ready", 32'(bus.rom_ready), 32'(0));
         end else begin
            m = exp_q.pop_front();
            check_eq("rom_data", 32'(bus.rom_data_out), 32'(m.data));
            if (m.kind == KIND_MISS)
               check_eq("miss_latency", 32'(cyc), 32'(valid_cyc + 1));
            else
               check_eq("hit_latency", 32'(cyc), 32'(m.cap_cyc + 2));
         end
      end
   end

   // Called at a negedge while the DUT is idle; returns at the negedge of the next idle cycle.
   task automatic do_read(input logic [31:0] a, input int kind, input int lat,
                          input bit inv_fill, input bit inv_lookup);
      exp_t e;
      int   rd0;
      bit   got;
      back_lat      = lat;
      fill_inval    = inv_fill;
      exp_back_addr = a[BACK_AW+1:2];
      e.data    = (kind == KIND_RANGE) ? 8'h00 : rom_byte(a);
      e.kind    = kind;
      e.cap_cyc = cyc;
      exp_q.push_back(e);
      rd0 = back_rd_cnt;
      bus.rom_addr    = a;
      bus.rom_read_en = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         inval_drv = inv_lookup && (i == 0);
         if (bus.rom_ready === 1'b1) got = 1'b1;
      end
      if (!got) begin
         check_eq("ready_timeout", 32'(bus.rom_ready), 32'(1));
         exp_q.delete();
      end
      @(negedge clk);
      inval_drv = 1'b0;
      check_eq("gap_no_ready", 32'(bus.rom_ready), 32'(0));
      check_eq("data_hold", 32'(bus.rom_data_out), 32'(e.data));
      check_eq("back_rd_count", 32'(back_rd_cnt - rd0), (kind == KIND_MISS) ? 32'(1) : 32'(0));
      @(negedge clk);
      bus.rom_read_en = 1'b0;
      if (kind == KIND_MISS) begin
         mdl_valid = !inv_fill;
         mdl_tag   = a[31:2];
      end
      if (inv_lookup) mdl_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int rd0;
      logic [31:0] a;
      int kind;
      rst             = 1'b1;
      inval_drv       = 1'b0;
      bus.rom_addr    = 32'h0;
      bus.rom_read_en = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_ready", 32'(bus.rom_ready), 32'(0));
      check_eq("rst_data", 32'(bus.rom_data_out), 32'(0));
      check_eq("rst_back_rd", 32'(bus.back_rd), 32'(0));
      check_eq("rst_back_addr", 32'(bus.back_addr), 32'(0));
      check_eq("rst_range_err", 32'(bus.range_err), 32'(0));
      rst = 1'b0;
      @(negedge clk);

      // Fill, then sequential hits within the word.
      do_read(32'h30, KIND_MISS, 3, 1'b0, 1'b0);
      do_read(32'h30, KIND_HIT, 0, 1'b0, 1'b0);
      do_read(32'h31, KIND_HIT, 0, 1'b0, 1'b0);
      do_read(32'h32, KIND_HIT, 0, 1'b0, 1'b0);
      do_read(32'h33, KIND_HIT, 0, 1'b0, 1'b0);
      do_read(32'h34, KIND_MISS, 2, 1'b0, 1'b0);
      do_read(32'h30, KIND_MISS, 5, 1'b0, 1'b0);

      // Stray back_valid while idle must not disturb the buffer.
      stray_req = 1'b1;
      repeat (3) @(negedge clk);
      do_read(32'h31, KIND_HIT, 0, 1'b0, 1'b0);

      // Out-of-range reads and sticky range_err.
      do_read(32'h1000, KIND_RANGE, 0, 1'b0, 1'b0);
      check_eq("range_err_set", 32'(bus.range_err), 32'(1));
      do_read(32'hFFFF_FFFF, KIND_RANGE, 0, 1'b0, 1'b0);
      do_read(32'h32, KIND_HIT, 0, 1'b0, 1'b0);
      check_eq("range_err_sticky", 32'(bus.range_err), 32'(1));

      // Invalidate racing a fill, then racing a lookup hit.
      do_read(32'h40, KIND_MISS, 3, 1'b1, 1'b0);
      do_read(32'h41, KIND_MISS, 2, 1'b0, 1'b0);
      do_read(32'h42, KIND_HIT, 0, 1'b0, 1'b1);
      do_read(32'h43, KIND_MISS, 1, 1'b0, 1'b0);

      // Reset in WAIT with the backing answer withheld.
      back_lat      = -1;
      exp_back_addr = BACK_AW'(32'h50 >> 2);
      rd0           = back_rd_cnt;
      bus.rom_addr    = 32'h50;
      bus.rom_read_en = 1'b1;
      @(negedge clk);
      bus.rom_read_en = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_eq("wait_rst_ready", 32'(bus.rom_ready), 32'(0));
      check_eq("wait_rst_data", 32'(bus.rom_data_out), 32'(0));
      check_eq("wait_rst_back_rd", 32'(bus.back_rd), 32'(0));
      check_eq("wait_rst_back_addr", 32'(bus.back_addr), 32'(0));
      check_eq("wait_rst_range_err", 32'(bus.range_err), 32'(0));
      check_eq("wait_rst_fetch_seen", 32'(back_rd_cnt - rd0), 32'(1));
      rst       = 1'b0;
      mdl_valid = 1'b0;
      repeat (6) @(negedge clk);
      do_read(32'h30, KIND_MISS, 3, 1'b0, 1'b0);

      // Random reads over a small window to mix hits and misses.
      for (int i = 0; i < 12; i++) begin
         a    = 32'($urandom_range(0, 127));
         kind = (mdl_valid && mdl_tag == a[31:2]) ? KIND_HIT : KIND_MISS;
         do_read(a, kind, int'($urandom_range(1, 4)), 1'b0, 1'b0);
      end

      repeat (5) @(negedge clk);
      check_eq("scoreboard_empty", 32'(exp_q.size()), 32'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bootrom_responder.md
Name: bootrom_responder

Overview:
- Serves the byte-wide boot ROM read handshake (rom_addr / rom_read_en / rom_ready / rom_data_out) on the responder side, feeding the WASM boot loader.
- Fetches 32-bit words from a variable-latency backing ROM port.
- Keeps a one-word buffer, so sequential byte reads within one word hit without a backing access.
- Flags out-of-range addresses.

Parameters:
- ROM_BYTES, 4096, size of the ROM in bytes. Addresses >= ROM_BYTES are out of range. Must be a multiple of 4.
- BACK_AW, 10, width of the backing word address. Must satisfy 2^BACK_AW >= ROM_BYTES/4.

Ports:
- clk  in  1  system clock; everything is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rom_addr  in  32  byte address from the loader.
- rom_read_en  in  1  loader read request level.
- rom_data_out  out  8  returned byte; valid while rom_ready=1, held until the next pulse.
- rom_ready  out  1  one-cycle pulse, data valid.
- back_addr  out  BACK_AW  word address to the backing ROM (rom_addr[BACK_AW+1:2]).
- back_rd  out  1  one-cycle backing read strobe.
- back_data  in  32  backing read word, little-endian byte lanes.
- back_valid  in  1  one-cycle strobe, back_data valid.
- inval  in  1  clears the word buffer (ROM remapped or reloaded).
- range_err  out  1  sticky: an out-of-range read was served.

Behaviour:
- Reset values (rst=1 at an edge):
  - rom_ready=0, rom_data_out=0x00, back_rd=0, back_addr=0, range_err=0.
  - Buffer valid=0, state=IDLE.
  - Reset overrides any operation in flight.
  - The backing ROM shares rst, so no stale back_valid arrives after reset.
- States: IDLE, LOOKUP, FETCH, WAIT, RESPOND, GAP.
- IDLE: if rom_read_en=1, capture rom_addr into req_addr and go to LOOKUP. Otherwise stay.
- LOOKUP (capture+1), checked in this priority:
  - req_addr >= ROM_BYTES: set data=0x00, set range_err, go to RESPOND.
  - Buffer valid and tag == req_addr[31:2]: select byte lane req_addr[1:0] and go to RESPOND.
  - Otherwise go to FETCH.
- FETCH: back_rd=1 for exactly this cycle, back_addr=req_addr[BACK_AW+1:2]. Go to WAIT.
- WAIT:
  - back_addr is held.
  - On back_valid: load the buffer (tag=req_addr[31:2], valid=1), select lane req_addr[1:0] into rom_data_out, go to RESPOND.
  - No timeout.
- RESPOND: rom_ready=1 for exactly one cycle, then go to GAP. rom_data_out keeps its value after the pulse.
- GAP: one dead cycle that ignores rom_read_en, then go to IDLE.
  - The loader updates rom_addr through a register in the cycle after the pulse.
  - The earliest new capture is therefore pulse+2.
- Latency, capture cycle c to rom_ready:
  - Hit or out-of-range: c+2.
  - Miss: back_valid cycle v, then ready at v+1.
  - Back-to-back hits complete every 4 cycles.
- rom_read_en dropping after capture does not cancel the transaction; the response still pulses.
- Lane selection: addr[1:0]=0 selects back_data[7:0], 1 selects [15:8], 2 selects [23:16], 3 selects [31:24].
- inval:
  - Clears buffer valid in any state.
  - If asserted in the same cycle as a back_valid fill, the current request still returns the fetched byte, but the buffer ends invalid (inval wins for the buffer).
  - If asserted in the same cycle as a LOOKUP hit, that lookup still hits.
- back_valid outside WAIT is ignored.
- range_err clears only on rst.
- Address wrap: there is no wrap. The full 32-bit compare against ROM_BYTES is used, so 0xFFFFFFFF is out of range.

Test Plan:
- Reset, then read 0x30. Backing returns word 0x44332211 three cycles after back_rd, with back_addr=0x0C. → rom_data_out=0x11, one-cycle rom_ready at v+1. No second pulse while rom_read_en stays high through GAP.
- Sequential reads 0x30, 0x31, 0x32, 0x33 after the fill in the test above. → Zero further back_rd; data 0x11, 0x22, 0x33, 0x44. Each hit's ready lands exactly 2 cycles after its capture.
- Read 0x34 after 0x33. → Miss, back_addr=0x0D, new tag installed. A re-read of 0x30 then misses again.
- ROM_BYTES=4096, read 0x1000. → No back_rd, rom_data_out=0x00, ready at c+2, range_err=1 and sticky through later valid reads.
- inval pulsed in the same cycle as back_valid for 0x40 (word 0xDDCCBBAA). → Returns 0xAA. A following read of 0x41 misses and issues back_rd.
- rst asserted in WAIT, then back_valid withheld. → All outputs return to reset values next cycle, no rom_ready pulse. A subsequent read of 0x30 performs a fresh fetch.
